// File: rtl/ex_pkg.sv
// Shared definitions for the EX stage: datapath defaults, ALU opcodes and multiplier FSM states.
package ex_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;
    localparam int DEF_IMM_W  = 5;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_ADDI = 4'd9;
    localparam logic [3:0] ALU_MUL  = 4'd10;

    typedef enum logic {
        MUL_IDLE,
        MUL_BUSY
    } mul_state_e;

endpackage

// File: rtl/alu8.sv
// Combinational ALU for single-cycle ops 0-9; every other opcode yields zero.
module alu8
    import ex_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IMM_W  = DEF_IMM_W
) (
    input  logic [3:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [IMM_W-1:0]  imm_i,
    output logic [DATA_W-1:0] y_o
);

    logic [DATA_W-1:0] imm_ext;

    assign imm_ext = {{(DATA_W-IMM_W){imm_i[IMM_W-1]}}, imm_i};

    always_comb begin
        y_o = '0;
        case (op_i)
            ALU_ADD:  y_o = a_i + b_i;
            ALU_SUB:  y_o = a_i - b_i;
            ALU_AND:  y_o = a_i & b_i;
            ALU_OR:   y_o = a_i | b_i;
            ALU_XOR:  y_o = a_i ^ b_i;
            ALU_NOR:  y_o = ~(a_i | b_i);
            ALU_SLL:  y_o = a_i << b_i[2:0];
            ALU_SRL:  y_o = a_i >> b_i[2:0];
            ALU_SLT:  y_o = {{(DATA_W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            ALU_ADDI: y_o = a_i + imm_ext;
            default:  y_o = '0;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// EX stage: operand forwarding, ALU, CB flag and the EX/MEM register.
// Define MULT_EN to enable the iterative shift-add multiplier for op 10 (otherwise op 10 is a bubble).
module execute_stage
    import ex_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int IMM_W  = DEF_IMM_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [3:0]        alucontrol_i,
    input  logic              write_i,
    input  logic              write_data_control_i,
    input  logic              CBwrite_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [DATA_W-1:0] rt_data_i,
    input  logic [ADDR_W-1:0] rs_addr_i,
    input  logic [ADDR_W-1:0] rt_addr_i,
    input  logic [ADDR_W-1:0] write_addr_i,
    input  logic [IMM_W-1:0]  immediate_i,
    input  logic              memwrite_i,
    input  logic              memread_i,
    input  logic              flush_i,
    input  logic              wb_write_i,
    input  logic [ADDR_W-1:0] wb_addr_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic              stall_o,
    output logic [DATA_W-1:0] alu_result_o,
    output logic [DATA_W-1:0] store_data_o,
    output logic [ADDR_W-1:0] write_addr_o,
    output logic              write_o,
    output logic              write_data_control_o,
    output logic              memwrite_o,
    output logic              memread_o,
    output logic              cb_flag_o
);

    logic [DATA_W-1:0] rs_fwd, rt_fwd, alu_y;
    logic [DATA_W-1:0] alu_result_q, alu_result_d, store_data_q, store_data_d;
    logic [ADDR_W-1:0] write_addr_q, write_addr_d;
    logic write_q, write_d, wdc_q, wdc_d, memwrite_q, memwrite_d;
    logic memread_q, memread_d, cb_q, cb_d;
    logic stall, reg_op;

`ifdef MULT_EN
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W-1);

    mul_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d, acc_q, acc_d;
`endif

    // A loaded value in EX/MEM is not yet available, so only ALU results forward from there.
    always_comb begin
        rs_fwd = rs_data_i;
        if (write_q && !memread_q && write_addr_q == rs_addr_i && rs_addr_i != '0)
            rs_fwd = alu_result_q;
        else if (wb_write_i && wb_addr_i == rs_addr_i && rs_addr_i != '0)
            rs_fwd = wb_data_i;
    end

    always_comb begin
        rt_fwd = rt_data_i;
        if (write_q && !memread_q && write_addr_q == rt_addr_i && rt_addr_i != '0)
            rt_fwd = alu_result_q;
        else if (wb_write_i && wb_addr_i == rt_addr_i && rt_addr_i != '0)
            rt_fwd = wb_data_i;
    end

    alu8 #(.DATA_W(DATA_W), .IMM_W(IMM_W)) u_alu (
        .op_i  (alucontrol_i),
        .a_i   (rs_fwd),
        .b_i   (rt_fwd),
        .imm_i (immediate_i),
        .y_o   (alu_y)
    );

    always_comb begin
        alu_result_d = alu_y;
        store_data_d = rt_fwd;
        write_addr_d = write_addr_i;
        write_d      = write_i;
        wdc_d        = write_data_control_i;
        memwrite_d   = memwrite_i;
        memread_d    = memread_i;
        cb_d         = cb_q;
        reg_op       = 1'b1;
        stall        = 1'b0;
`ifdef MULT_EN
        state_d = state_q;
        cnt_d   = cnt_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        acc_d   = acc_q;

        if (flush_i) begin
            reg_op  = 1'b0;
            state_d = MUL_IDLE;
        end else if (state_q == MUL_BUSY) begin
            // One partial product per cycle; the last step's sum goes straight into EX/MEM.
            acc_d = acc_q + (mul_b_q[cnt_q] ? (mul_a_q << cnt_q) : '0);
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q != CNT_LAST) begin
                stall  = 1'b1;
                reg_op = 1'b0;
            end else begin
                alu_result_d = acc_d;
                store_data_d = mul_b_q;
                state_d      = MUL_IDLE;
            end
        end else if (alucontrol_i == ALU_MUL) begin
            mul_a_d = rs_fwd;
            mul_b_d = rt_fwd;
            acc_d   = '0;
            cnt_d   = '0;
            stall   = 1'b1;
            reg_op  = 1'b0;
            state_d = MUL_BUSY;
        end
`else
        if (flush_i || alucontrol_i == ALU_MUL)
            reg_op = 1'b0;
`endif

        if (!reg_op) begin
            alu_result_d = '0;
            store_data_d = '0;
            write_addr_d = '0;
            write_d      = 1'b0;
            wdc_d        = 1'b0;
            memwrite_d   = 1'b0;
            memread_d    = 1'b0;
        end else if (CBwrite_i) begin
            cb_d = (alu_result_d != '0);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            alu_result_q <= '0;
            store_data_q <= '0;
            write_addr_q <= '0;
            write_q      <= 1'b0;
            wdc_q        <= 1'b0;
            memwrite_q   <= 1'b0;
            memread_q    <= 1'b0;
            cb_q         <= 1'b0;
        end else begin
            alu_result_q <= alu_result_d;
            store_data_q <= store_data_d;
            write_addr_q <= write_addr_d;
            write_q      <= write_d;
            wdc_q        <= wdc_d;
            memwrite_q   <= memwrite_d;
            memread_q    <= memread_d;
            cb_q         <= cb_d;
        end
    end

`ifdef MULT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= MUL_IDLE;
            cnt_q   <= '0;
            mul_a_q <= '0;
            mul_b_q <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            acc_q   <= acc_d;
        end
    end
`endif

    // Reset must release the front end even while a MUL sits in ID/EX.
    assign stall_o              = stall & ~rst_i;
    assign alu_result_o         = alu_result_q;
    assign store_data_o         = store_data_q;
    assign write_addr_o         = write_addr_q;
    assign write_o              = write_q;
    assign write_data_control_o = wdc_q;
    assign memwrite_o           = memwrite_q;
    assign memread_o            = memread_q;
    assign cb_flag_o            = cb_q;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed cases plus randomized traffic against a behavioural model.
// Honors MULT_EN the same way as the design.
`timescale 1ns/1ps
module tb_execute_stage;
    import ex_pkg::*;

    typedef struct {
        logic [3:0] op;
        logic       wr, wdc, cbw, mw, mr, flush, wbW;
        logic [7:0] rsD, rtD, wbD;
        logic [2:0] rsA, rtA, wA, wbA;
        logic [4:0] imm;
    } stim_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] alucontrol_i;
    logic       write_i, write_data_control_i, CBwrite_i, memwrite_i, memread_i, flush_i, wb_write_i;
    logic [7:0] rs_data_i, rt_data_i, wb_data_i;
    logic [2:0] rs_addr_i, rt_addr_i, write_addr_i, wb_addr_i;
    logic [4:0] immediate_i;
    logic       stall_o, write_o, write_data_control_o, memwrite_o, memread_o, cb_flag_o;
    logic [7:0] alu_result_o, store_data_o;
    logic [2:0] write_addr_o;

    int assertCount = 0;
    int failCount   = 0;

    logic [7:0] mResult, mStore, mProd, mOpB;
    logic [2:0] mAddr;
    logic       mWrite, mWdc, mMw, mMr, mCb;
    bit         mBusy;
    int         mDone;
    bit         lastStallObs, lastStallExp;
    stim_t      s;

    always #5 clk = ~clk;

    execute_stage dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .alucontrol_i         (alucontrol_i),
        .write_i              (write_i),
        .write_data_control_i (write_data_control_i),
        .CBwrite_i            (CBwrite_i),
        .rs_data_i            (rs_data_i),
        .rt_data_i            (rt_data_i),
        .rs_addr_i            (rs_addr_i),
        .rt_addr_i            (rt_addr_i),
        .write_addr_i         (write_addr_i),
        .immediate_i          (immediate_i),
        .memwrite_i           (memwrite_i),
        .memread_i            (memread_i),
        .flush_i              (flush_i),
        .wb_write_i           (wb_write_i),
        .wb_addr_i            (wb_addr_i),
        .wb_data_i            (wb_data_i),
        .stall_o              (stall_o),
        .alu_result_o         (alu_result_o),
        .store_data_o         (store_data_o),
        .write_addr_o         (write_addr_o),
        .write_o              (write_o),
        .write_data_control_o (write_data_control_o),
        .memwrite_o           (memwrite_o),
        .memread_o            (memread_o),
        .cb_flag_o            (cb_flag_o)
    );

    task automatic checkVal(input string name, input logic [7:0] act, input logic [7:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: actual=0x%02h required=0x%02h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] aluRef(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                          input logic [4:0] imm);
        int ia, ib, sa, sb, si;
        ia = int'(a);
        ib = int'(b);
        sa = (ia > 127) ? ia - 256 : ia;
        sb = (ib > 127) ? ib - 256 : ib;
        si = int'(imm);
        if (si > 15) si = si - 32;
        case (op)
            ALU_ADD:  return 8'(ia + ib);
            ALU_SUB:  return 8'(ia - ib);
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_NOR:  return ~(a | b);
            ALU_SLL:  return 8'(ia * (1 << (ib % 8)));
            ALU_SRL:  return 8'(ia / (1 << (ib % 8)));
            ALU_SLT:  return (sa < sb) ? 8'd1 : 8'd0;
            ALU_ADDI: return 8'(ia + si);
            ALU_MUL:  return 8'(ia * ib);
            default:  return 8'd0;
        endcase
    endfunction

    function automatic logic [7:0] fwdRef(input logic [2:0] addr, input logic [7:0] data);
        if (mWrite && !mMr && mAddr == addr && addr != 3'd0) return mResult;
        if (wb_write_i && wb_addr_i == addr && addr != 3'd0) return wb_data_i;
        return data;
    endfunction

    function automatic bit expStall();
`ifdef MULT_EN
        if (flush_i) return 1'b0;
        if (mBusy) return (mDone < 8);
        return (alucontrol_i == ALU_MUL);
`else
        return 1'b0;
`endif
    endfunction

    task automatic modelReset();
        mResult = 8'd0; mStore = 8'd0; mAddr = 3'd0;
        mWrite = 1'b0; mWdc = 1'b0; mMw = 1'b0; mMr = 1'b0; mCb = 1'b0;
        mBusy = 1'b0; mDone = 0; mProd = 8'd0; mOpB = 8'd0;
        lastStallExp = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs currently on the pins.
    task automatic modelStep();
        logic [7:0] a, b, res;
        bit regOp;
        a = fwdRef(rs_addr_i, rs_data_i);
        b = fwdRef(rt_addr_i, rt_data_i);
        regOp = 1'b0;
        res = 8'd0;
        if (flush_i) begin
            mBusy = 1'b0;
        end else if (mBusy) begin
            if (mDone < 8) begin
                mDone++;
            end else begin
                mBusy = 1'b0;
                regOp = 1'b1;
                res = mProd;
                b = mOpB;
            end
        end else if (alucontrol_i == ALU_MUL) begin
`ifdef MULT_EN
            mBusy = 1'b1;
            mDone = 1;
            mProd = aluRef(ALU_MUL, a, b, 5'd0);
            mOpB = b;
`endif
        end else begin
            regOp = 1'b1;
            res = aluRef(alucontrol_i, a, b, immediate_i);
        end
        if (regOp) begin
            mResult = res; mStore = b; mAddr = write_addr_i;
            mWrite = write_i; mWdc = write_data_control_i; mMw = memwrite_i; mMr = memread_i;
            if (CBwrite_i) mCb = (res != 8'd0);
        end else begin
            mResult = 8'd0; mStore = 8'd0; mAddr = 3'd0;
            mWrite = 1'b0; mWdc = 1'b0; mMw = 1'b0; mMr = 1'b0;
        end
    endtask

    task automatic applyStimulus(input stim_t st);
        @(negedge clk);
        alucontrol_i = st.op; write_i = st.wr; write_data_control_i = st.wdc; CBwrite_i = st.cbw;
        rs_data_i = st.rsD; rt_data_i = st.rtD; rs_addr_i = st.rsA; rt_addr_i = st.rtA;
        write_addr_i = st.wA; immediate_i = st.imm; memwrite_i = st.mw; memread_i = st.mr;
        flush_i = st.flush; wb_write_i = st.wbW; wb_addr_i = st.wbA; wb_data_i = st.wbD;
    endtask

    task automatic zeroInputs();
        alucontrol_i = 4'd0; write_i = 1'b0; write_data_control_i = 1'b0; CBwrite_i = 1'b0;
        rs_data_i = 8'd0; rt_data_i = 8'd0; rs_addr_i = 3'd0; rt_addr_i = 3'd0;
        write_addr_i = 3'd0; immediate_i = 5'd0; memwrite_i = 1'b0; memread_i = 1'b0;
        flush_i = 1'b0; wb_write_i = 1'b0; wb_addr_i = 3'd0; wb_data_i = 8'd0;
    endtask

    task automatic checkOutput();
        checkVal("alu_result", alu_result_o, mResult);
        checkVal("store_data", store_data_o, mStore);
        checkVal("write_addr", 8'(write_addr_o), 8'(mAddr));
        checkVal("write", 8'(write_o), 8'(mWrite));
        checkVal("write_data_control", 8'(write_data_control_o), 8'(mWdc));
        checkVal("memwrite", 8'(memwrite_o), 8'(mMw));
        checkVal("memread", 8'(memread_o), 8'(mMr));
        checkVal("cb_flag", 8'(cb_flag_o), 8'(mCb));
    endtask

    task automatic checkAllZero(input string tag);
        checkVal({tag, "_result"}, alu_result_o, 8'h00);
        checkVal({tag, "_store"}, store_data_o, 8'h00);
        checkVal({tag, "_addr"}, 8'(write_addr_o), 8'h00);
        checkVal({tag, "_write"}, 8'(write_o), 8'h00);
        checkVal({tag, "_wdc"}, 8'(write_data_control_o), 8'h00);
        checkVal({tag, "_memwrite"}, 8'(memwrite_o), 8'h00);
        checkVal({tag, "_memread"}, 8'(memread_o), 8'h00);
        checkVal({tag, "_cb"}, 8'(cb_flag_o), 8'h00);
        checkVal({tag, "_stall"}, 8'(stall_o), 8'h00);
    endtask

    // One cycle: stall is checked with the new inputs settled, registers just after the edge.
    task automatic runCycle();
        bit es;
        #1;
        es = expStall();
        lastStallObs = stall_o;
        lastStallExp = es;
        checkVal("stall", 8'(stall_o), 8'(es));
        modelStep();
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic asyncReset(input string tag);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkAllZero(tag);
        modelReset();
        @(negedge clk);
        zeroInputs();
        rst = 1'b0;
    endtask

    task automatic doMul(input stim_t st, input logic [7:0] expResult, input string tag);
        int stallCnt;
        applyStimulus(st);
        stallCnt = 0;
        for (int i = 0; i < 12; i++) begin
            runCycle();
            if (!lastStallObs) break;
            stallCnt++;
        end
        checkVal({tag, "_stall_cycles"}, 8'(stallCnt), 8'd8);
        checkVal({tag, "_result"}, alu_result_o, expResult);
        checkVal({tag, "_write"}, 8'(write_o), 8'd1);
    endtask

    function automatic stim_t mkStim(input logic [3:0] op, input logic [2:0] rsA, input logic [7:0] rsD,
                                     input logic [2:0] rtA, input logic [7:0] rtD, input logic [2:0] wA,
                                     input logic [4:0] imm, input logic wr, input logic cbw);
        stim_t st;
        st.op = op; st.rsA = rsA; st.rsD = rsD; st.rtA = rtA; st.rtD = rtD; st.wA = wA;
        st.imm = imm; st.wr = wr; st.cbw = cbw;
        st.wdc = 1'b0; st.mw = 1'b0; st.mr = 1'b0; st.flush = 1'b0;
        st.wbW = 1'b0; st.wbA = 3'd0; st.wbD = 8'd0;
        return st;
    endfunction

    function automatic stim_t randStim();
        stim_t st;
        st.op    = ($urandom_range(0, 4) == 0) ? ALU_MUL : 4'($urandom_range(0, 15));
        st.rsA   = 3'($urandom_range(0, 7));
        st.rtA   = 3'($urandom_range(0, 7));
        st.wA    = 3'($urandom_range(0, 7));
        st.wbA   = 3'($urandom_range(0, 7));
        st.rsD   = 8'($urandom);
        st.rtD   = 8'($urandom);
        st.wbD   = 8'($urandom);
        st.imm   = 5'($urandom);
        st.wr    = 1'($urandom);
        st.wdc   = 1'($urandom);
        st.cbw   = 1'($urandom);
        st.mw    = 1'($urandom);
        st.mr    = 1'($urandom);
        st.wbW   = 1'($urandom);
        st.flush = ($urandom_range(0, 9) == 0);
        return st;
    endfunction

    initial begin
        rst = 1'b1;
        zeroInputs();
        modelReset();
        @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;

        $display("[TB] ADD and forwarding cases");
        s = mkStim(ALU_ADD, 3'd1, 8'h7F, 3'd2, 8'h01, 3'd5, 5'd0, 1'b1, 1'b1);
        applyStimulus(s); runCycle();
        checkVal("add_7f_01", alu_result_o, 8'h80);
        checkVal("add_write", 8'(write_o), 8'd1);
        checkVal("model_add_7f_01", mResult, 8'h80);

        s = mkStim(ALU_ADD, 3'd1, 8'h08, 3'd2, 8'h08, 3'd3, 5'd0, 1'b1, 1'b0);
        applyStimulus(s); runCycle();
        checkVal("add_r3", alu_result_o, 8'h10);
        s = mkStim(ALU_ADD, 3'd3, 8'h00, 3'd3, 8'h00, 3'd4, 5'd0, 1'b1, 1'b0);
        s.wbW = 1'b1; s.wbA = 3'd3; s.wbD = 8'h55;
        applyStimulus(s); runCycle();
        checkVal("exmem_fwd_priority", alu_result_o, 8'h20);
        checkVal("model_exmem_fwd", mResult, 8'h20);

        s = mkStim(ALU_ADDI, 3'd1, 8'h05, 3'd2, 8'h00, 3'd0, 5'h1F, 1'b1, 1'b0);
        applyStimulus(s); runCycle();
        checkVal("addi_neg1", alu_result_o, 8'h04);
        s = mkStim(ALU_ADD, 3'd0, 8'h01, 3'd0, 8'h02, 3'd6, 5'd0, 1'b1, 1'b0);
        s.wbW = 1'b1; s.wbA = 3'd0; s.wbD = 8'h99;
        applyStimulus(s); runCycle();
        checkVal("r0_no_forward", alu_result_o, 8'h03);

        $display("[TB] CB flag cases");
        s = mkStim(ALU_SUB, 3'd1, 8'h33, 3'd2, 8'h33, 3'd7, 5'd0, 1'b1, 1'b1);
        applyStimulus(s); runCycle();
        checkVal("sub_zero_cb", 8'(cb_flag_o), 8'd0);
        s = mkStim(ALU_SLT, 3'd1, 8'h80, 3'd2, 8'h01, 3'd7, 5'd0, 1'b1, 1'b1);
        applyStimulus(s); runCycle();
        checkVal("slt_signed", alu_result_o, 8'h01);
        checkVal("slt_cb", 8'(cb_flag_o), 8'd1);
        checkVal("model_slt", mResult, 8'h01);
        s = mkStim(ALU_SUB, 3'd1, 8'h33, 3'd2, 8'h33, 3'd7, 5'd0, 1'b1, 1'b1);
        s.flush = 1'b1;
        applyStimulus(s); runCycle();
        checkVal("flush_cb_hold", 8'(cb_flag_o), 8'd1);
        checkVal("flush_write", 8'(write_o), 8'd0);

`ifdef MULT_EN
        $display("[TB] Multiplier cases");
        s = mkStim(ALU_MUL, 3'd4, 8'h0D, 3'd5, 8'h0B, 3'd2, 5'd0, 1'b1, 1'b0);
        doMul(s, 8'h8F, "mul_0d_0b");
        s = mkStim(ALU_MUL, 3'd4, 8'hFF, 3'd5, 8'hFF, 3'd2, 5'd0, 1'b1, 1'b0);
        doMul(s, 8'h01, "mul_ff_ff");

        s = mkStim(ALU_MUL, 3'd4, 8'h0D, 3'd5, 8'h0B, 3'd2, 5'd0, 1'b1, 1'b0);
        applyStimulus(s);
        repeat (4) runCycle();
        s.flush = 1'b1;
        applyStimulus(s);
        #1;
        checkVal("flush_busy_stall", 8'(stall_o), 8'd0);
        runCycle();
        checkVal("flush_busy_write", 8'(write_o), 8'd0);
        s = mkStim(ALU_ADD, 3'd4, 8'h01, 3'd5, 8'h02, 3'd3, 5'd0, 1'b1, 1'b0);
        applyStimulus(s); runCycle();
        checkVal("after_flush_idle_stall", 8'(lastStallObs), 8'd0);
        checkVal("after_flush_add", alu_result_o, 8'h03);
`else
        $display("[TB] Illegal MUL case");
        s = mkStim(ALU_MUL, 3'd4, 8'h0D, 3'd5, 8'h0B, 3'd2, 5'd0, 1'b1, 1'b0);
        s.mw = 1'b1;
        applyStimulus(s); runCycle();
        checkVal("mul_off_stall", 8'(lastStallObs), 8'd0);
        checkVal("mul_off_result", alu_result_o, 8'h00);
        checkVal("mul_off_write", 8'(write_o), 8'd0);
        checkVal("mul_off_memwrite", 8'(memwrite_o), 8'd0);
`endif

        $display("[TB] Asynchronous reset case");
        s = mkStim(ALU_ADD, 3'd4, 8'h21, 3'd5, 8'h01, 3'd6, 5'd0, 1'b1, 1'b1);
        applyStimulus(s); runCycle();
        checkVal("pre_reset_add", alu_result_o, 8'h22);
`ifdef MULT_EN
        s = mkStim(ALU_MUL, 3'd4, 8'h0D, 3'd5, 8'h0B, 3'd2, 5'd0, 1'b1, 1'b0);
        applyStimulus(s);
        repeat (3) runCycle();
`endif
        asyncReset("async_reset");
        s = mkStim(ALU_OR, 3'd1, 8'hA0, 3'd2, 8'h05, 3'd1, 5'd0, 1'b1, 1'b0);
        applyStimulus(s); runCycle();
        checkVal("post_reset_or", alu_result_o, 8'hA5);

        $display("[TB] Randomized traffic");
        for (int i = 0; i < 400; i++) begin
            if (lastStallExp) begin
                s.flush = ($urandom_range(0, 9) == 0);
                s.wbW   = 1'($urandom);
                s.wbA   = 3'($urandom_range(0, 7));
                s.wbD   = 8'($urandom);
            end else begin
                s = randStim();
            end
            applyStimulus(s);
            runCycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
